// File: rtl/adder_result_stage.sv
// Adder result stage: 2-entry skid buffer with NZCV flag capture and a saturating overflow counter.
// Optional build macro ADDER_RESULT_SAT_EN clamps the result on signed overflow.
module adder_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_count
);

    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_res;
    logic [3:0]       r_m_flags;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_res;
    logic [3:0]       r_s_flags;
    logic [CNT_W-1:0] r_ovf_count;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_v;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_flags;

    assign in_ready   = !r_s_valid;
    assign w_in_fire  = in_valid && !r_s_valid;
    assign w_out_fire = r_m_valid && out_ready;

    // Signed overflow: operands agree in sign but the sum does not.
    assign w_v = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);

`ifdef ADDER_RESULT_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        w_res = sum;
        if (w_v) begin
            w_res = a_msb ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign w_res = sum;
`endif

    assign w_flags = {w_res[WIDTH-1], (w_res == '0), cout, w_v};

    // in_ready is low whenever S is full, so S->M moves never coincide with an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_res   <= '0;
            r_m_flags <= '0;
            r_s_valid <= 1'b0;
            r_s_res   <= '0;
            r_s_flags <= '0;
        end else if (w_out_fire) begin
            if (r_s_valid) begin
                r_m_res   <= r_s_res;
                r_m_flags <= r_s_flags;
                r_s_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_m_res   <= w_res;
                r_m_flags <= w_flags;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            if (!r_m_valid) begin
                r_m_valid <= 1'b1;
                r_m_res   <= w_res;
                r_m_flags <= w_flags;
            end else begin
                r_s_valid <= 1'b1;
                r_s_res   <= w_res;
                r_s_flags <= w_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (cnt_clr) begin
            r_ovf_count <= '0;
        end else if (w_in_fire && w_v && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
    end

    assign out_valid = r_m_valid;
    assign result    = r_m_res;
    assign flags     = r_m_flags;
    assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage: expected entries queued on accept, compared on output handshake.
module tb_adder_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             a_msb;
    logic             b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             cnt_clr;
    logic [CNT_W-1:0] ovf_count;

    adder_result_stage #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum      (sum),
        .cout     (cout),
        .a_msb    (a_msb),
        .b_msb    (b_msb),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags),
        .cnt_clr  (cnt_clr),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    int unsigned     n_vec = 0;
    int unsigned     n_err = 0;
    logic [35:0]     sb_q[$];
    logic [CNT_W-1:0] m_cnt = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {result, N, Z, C, V} from the adder outputs.
    function automatic logic [35:0] model(input logic [31:0] s, input logic c, input logic a, input logic b);
        logic        v;
        logic [31:0] r;
        v = (a == b) && (s[31] != a);
        r = s;
`ifdef ADDER_RESULT_SAT_EN
        if (v) r = a ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {r, r[31], (r == 32'h0), c, v};
    endfunction

    // Called at the negedge with inputs already driven; advances one clock.
    task automatic tick();
        logic [35:0] e;
        logic        fire_in;
        check_eq("out_valid", out_valid, sb_q.size() > 0);
        check_eq("in_ready", in_ready, sb_q.size() < 2);
        check_eq("ovf_count", ovf_count, m_cnt);
        if (out_valid && out_ready && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("result", result, e[35:4]);
            check_eq("flags", flags, e[3:0]);
        end
        fire_in = in_valid && in_ready;
        e = model(sum, cout, a_msb, b_msb);
        if (fire_in) sb_q.push_back(e);
        if (cnt_clr) m_cnt = '0;
        else if (fire_in && e[0] && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] s, input logic c, input logic a, input logic b);
        logic acc;
        in_valid = 1'b1;
        sum      = s;
        cout     = c;
        a_msb    = a;
        b_msb    = b;
        acc      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        check_eq("send_accept", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        sum       = '0;
        cout      = 1'b0;
        a_msb     = 1'b0;
        b_msb     = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_result", result, 32'h0);
        check_eq("rst_flags", flags, 4'h0);
        check_eq("rst_ovf", ovf_count, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed flag vectors.
        send(32'h8000_0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        send(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
        send(32'h0000_0000, 1'b1, 1'b0, 1'b1);
        idle(2);
        check_eq("ovf_after_directed", ovf_count, 4'd2);

        // Backpressure: third entry must stall until the consumer drains.
        out_ready = 1'b0;
        send(32'h1, 1'b0, 1'b0, 1'b0);
        send(32'h2, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        sum      = 32'h3;
        check_eq("third_blocked", in_ready, 1'b0);
        tick();
        tick();
        out_ready = 1'b1;
        send(32'h3, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Streaming at full rate.
        for (int i = 0; i < 20; i++) begin
            send($urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        idle(2);

        // Counter saturation, then clear beating a same-cycle overflow.
        for (int i = 0; i < 20; i++) send(32'h8000_0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_eq("cnt_sat", ovf_count, 4'hF);
        cnt_clr = 1'b1;
        send(32'h8000_0000, 1'b0, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        check_eq("cnt_clr_prio", ovf_count, 4'h0);
        idle(2);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            sum       = $urandom;
            cout      = 1'($urandom);
            a_msb     = 1'($urandom);
            b_msb     = 1'($urandom);
            cnt_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        idle(5);

        // Asynchronous reset with both entries full.
        out_ready = 1'b0;
        send(32'h8000_0000, 1'b0, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        check_eq("full_in_ready", in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_in_ready", in_ready, 1'b1);
        check_eq("arst_ovf", ovf_count, 4'h0);
        check_eq("arst_result", result, 32'h0);
        check_eq("arst_flags", flags, 4'h0);
        sb_q.delete();
        m_cnt = '0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        send(32'h5, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_eq("drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
